lightpen_latch: RTL and testbench
=================================

// Module: lightpen_latch
// PURPOSE
//  Light-pen capture stage feeding the status register's LPSET bit. Synchronises
//  and debounces the async pen trigger, then latches the raster position (HC/VC)
//  once per frame with pipeline-latency correction. Holds LPSET high until the
//  host acknowledges the capture with a read strobe.
// PARAMETERS
//  HCW          9   horizontal counter width (bits)
//  VCW          9   vertical counter width (bits)
//  SYNC_STAGES  2   flops in the LPENL synchroniser (>=2)
//  DEBOUNCE     3   consecutive synced-low samples required for a hit (1..15)
// PORTS
//  CLK          in   1    system clock; all state on rising edge
//  RESETL_0     in   1    asynchronous active-low reset
//  LPENL        in   1    pen trigger, async to CLK, active low
//  LPEN_EN      in   1    capture enable (host-written control bit)
//  HC           in   HCW  current horizontal raster count
//  VC           in   VCW  current vertical raster count
//  VSTART       in   1    one-CLK strobe at frame start
//  LPRD         in   1    one-CLK strobe: host has read LPH/LPV (acknowledge)
//  LPSET        out  1    capture valid; drives status register bit 1
//  LPH          out  HCW  captured horizontal position (latency-corrected)
//  LPV          out  VCW  captured vertical position
//  LPMISS       out  1    frame started while a capture was still unacknowledged
// BEHAVIOUR
//  Reset: LPSET=0, LPMISS=0, LPH=0, LPV=0, sync chain = all 1s, state=IDLE, dcnt=0.
//  Sync: LPENL through SYNC_STAGES flops -> pen_s (active low). No other path from LPENL.
//  States: IDLE, ARMED, FILTER, HELD (2-bit encoded).
//   IDLE   -> ARMED  on VSTART & LPEN_EN.
//   ARMED  -> FILTER on pen_s==0 (dcnt<=1). VSTART re-arms (stays ARMED).
//   FILTER: pen_s==0 -> dcnt+1; pen_s==1 -> ARMED, dcnt<=0.
//           dcnt reaching DEBOUNCE -> capture, LPSET<=1, -> HELD (same edge).
//           DEBOUNCE==1: capture on the first low sample (ARMED -> HELD directly).
//           VSTART in FILTER -> ARMED, dcnt<=0 (hit spanning frame boundary discarded).
//   HELD   -> IDLE on LPRD: LPSET<=0, LPMISS<=0. Pen activity ignored.
//   LPEN_EN=0 in ARMED/FILTER -> IDLE next edge; HELD is unaffected (data kept until LPRD).
//  Capture: LPH <= (HC - LAT) mod 2^HCW, LAT = SYNC_STAGES + DEBOUNCE; LPV <= VC
//   (no vertical correction; wrap on HC underflow is modular, by design).
//  LPH/LPV stable whenever LPSET=1; updated only on capture edge.
//  LPMISS: set on VSTART while HELD; cleared only by LPRD or reset.
//  Simultaneous: LPRD+VSTART in HELD -> LPRD wins (IDLE, LPMISS=0), no arm this frame.
//   LPRD outside HELD -> no effect. VSTART+capture same edge in FILTER -> VSTART wins.
//  Latency: LPENL fall to LPSET rise = SYNC_STAGES + DEBOUNCE CLKs (armed, stable low).
//  Reset mid-operation: async return to reset values, capture discarded.
// TESTING
//  1 Defaults: VSTART, LPEN_EN=1; LPENL low from HC=100, VC=50 -> LPSET=1 after 5 CLKs,
//    LPH=100, LPV=50; LPRD -> LPSET=0 next edge, state IDLE.
//  2 Glitch: LPENL low for 2 CLKs then high -> LPSET stays 0; later 6-CLK pulse captures.
//  3 Wrap: hit with HC=2 when sampled (LAT=5) -> LPH=509 (0x1FD).
//  4 Overrun: capture, no LPRD, VSTART -> LPMISS=1, LPH/LPV unchanged; LPRD clears both
//    flags; same-edge LPRD+VSTART -> LPMISS stays 0.
//  5 Enable/abort: LPEN_EN=0 during FILTER -> no capture; VSTART during FILTER -> dcnt
//    restarts; LPENL held low with no VSTART since reset -> LPSET stays 0.
//  6 Reset: assert RESETL_0 in FILTER and in HELD -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/lightpen_latch.sv
// Light-pen capture: synchronises and debounces the pen trigger, then latches the
// latency-corrected raster position once per frame until the host acknowledges it.
module lightpen_latch #(
  parameter int unsigned HCW         = 9,
  parameter int unsigned VCW         = 9,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 3
) (
  input  logic           CLK,
  input  logic           RESETL_0,
  input  logic           LPENL,
  input  logic           LPEN_EN,
  input  logic [HCW-1:0] HC,
  input  logic [VCW-1:0] VC,
  input  logic           VSTART,
  input  logic           LPRD,
  output logic           LPSET,
  output logic [HCW-1:0] LPH,
  output logic [VCW-1:0] LPV,
  output logic           LPMISS
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    FILTER = 2'd2,
    HELD   = 2'd3
  } state_t;

  localparam logic [HCW-1:0] LAT = HCW'(SYNC_STAGES + DEBOUNCE);
  localparam logic [3:0]     DB  = 4'(DEBOUNCE);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pen_s;
  state_t                 state;
  logic [3:0]             dcnt;

  always_ff @(posedge CLK or negedge RESETL_0) begin
    if (!RESETL_0) sync_q <= '1;
    else           sync_q <= {sync_q[SYNC_STAGES-2:0], LPENL};
  end

  assign pen_s = sync_q[SYNC_STAGES-1];

  // LPH is offset by the sync+debounce delay so it reports where the pen actually was.
  always_ff @(posedge CLK or negedge RESETL_0) begin
    if (!RESETL_0) begin
      state  <= IDLE;
      dcnt   <= '0;
      LPSET  <= 1'b0;
      LPMISS <= 1'b0;
      LPH    <= '0;
      LPV    <= '0;
    end else begin
      case (state)
        IDLE: begin
          dcnt <= '0;
          if (VSTART && LPEN_EN) state <= ARMED;
        end
        ARMED: begin
          if (!LPEN_EN) begin
            state <= IDLE;
            dcnt  <= '0;
          end else if (VSTART) begin
            dcnt <= '0;
          end else if (!pen_s) begin
            if (DB == 4'd1) begin
              LPH   <= HC - LAT;
              LPV   <= VC;
              LPSET <= 1'b1;
              dcnt  <= '0;
              state <= HELD;
            end else begin
              dcnt  <= 4'd1;
              state <= FILTER;
            end
          end
        end
        FILTER: begin
          // A frame start discards a partial hit even if this edge would have completed it.
          if (!LPEN_EN) begin
            state <= IDLE;
            dcnt  <= '0;
          end else if (VSTART || pen_s) begin
            state <= ARMED;
            dcnt  <= '0;
          end else if (dcnt + 4'd1 == DB) begin
            LPH   <= HC - LAT;
            LPV   <= VC;
            LPSET <= 1'b1;
            dcnt  <= '0;
            state <= HELD;
          end else begin
            dcnt <= dcnt + 4'd1;
          end
        end
        HELD: begin
          dcnt <= '0;
          if (LPRD) begin
            LPSET  <= 1'b0;
            LPMISS <= 1'b0;
            state  <= IDLE;
          end else if (VSTART) begin
            LPMISS <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          dcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lightpen_latch.sv
// Bench for lightpen_latch: expected captures are queued when a hit is driven and
// compared when LPSET rises; directed checks cover latency, abort and reset cases.
module tb_lightpen_latch;

  localparam int unsigned LAT = 5;

  logic       CLK = 1'b0;
  logic       RESETL_0 = 1'b0;
  logic       LPENL = 1'b1;
  logic       LPEN_EN = 1'b0;
  logic [8:0] HC = '0;
  logic [8:0] VC = '0;
  logic       VSTART = 1'b0;
  logic       LPRD = 1'b0;
  logic       LPSET;
  logic [8:0] LPH;
  logic [8:0] LPV;
  logic       LPMISS;

  typedef struct packed {
    logic [8:0] h;
    logic [8:0] v;
  } cap_t;

  cap_t        sb_q[$];
  cap_t        exp_cap;
  cap_t        held_cap;
  bit          held_ok = 1'b0;
  bit          hc_run = 1'b0;
  logic        prev_lpset = 1'b0;
  int unsigned errors = 0;
  int unsigned checks = 0;

  lightpen_latch #(
    .HCW(9),
    .VCW(9),
    .SYNC_STAGES(2),
    .DEBOUNCE(3)
  ) dut (
    .CLK(CLK),
    .RESETL_0(RESETL_0),
    .LPENL(LPENL),
    .LPEN_EN(LPEN_EN),
    .HC(HC),
    .VC(VC),
    .VSTART(VSTART),
    .LPRD(LPRD),
    .LPSET(LPSET),
    .LPH(LPH),
    .LPV(LPV),
    .LPMISS(LPMISS)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (hc_run) HC = HC + 9'd1;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_vstart();
    VSTART = 1'b1;
    tick();
    VSTART = 1'b0;
  endtask

  task automatic pulse_lprd();
    LPRD = 1'b1;
    tick();
    LPRD = 1'b0;
  endtask

  // Called right after LPENL falls; capture lands on the given edge after the fall.
  task automatic expect_hit(input int unsigned edges);
    cap_t       c;
    logic [8:0] hs;
    hs  = hc_run ? HC + 9'(edges - 1) : HC;
    c.h = hs - 9'(LAT);
    c.v = VC;
    sb_q.push_back(c);
  endtask

  task automatic wait_lpset(input int unsigned max);
    bit seen;
    seen = 1'b0;
    for (int unsigned i = 0; i < max && !seen; i++) begin
      tick();
      seen = LPSET;
    end
    check("lpset_timeout", 32'(seen), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_lpset"}, 32'(LPSET), 32'd0);
    check({tag, "_lph"}, 32'(LPH), 32'd0);
    check({tag, "_lpv"}, 32'(LPV), 32'd0);
    check({tag, "_lpmiss"}, 32'(LPMISS), 32'd0);
  endtask

  always @(negedge CLK) begin
    if (!RESETL_0) begin
      held_ok = 1'b0;
    end else if (LPSET && !prev_lpset) begin
      check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        exp_cap = sb_q.pop_front();
        check("cap_lph", 32'(LPH), 32'(exp_cap.h));
        check("cap_lpv", 32'(LPV), 32'(exp_cap.v));
        held_cap = exp_cap;
        held_ok  = 1'b1;
      end
    end else if (LPSET && held_ok) begin
      check("hold_stable", 32'({LPH, LPV}), 32'(held_cap));
    end
    prev_lpset = LPSET;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check_zero("reset");
    @(posedge CLK);
    #1;
    RESETL_0 = 1'b1;
    ticks(2);

    // Defaults: pen at raster 100 reported after five clocks
    LPEN_EN = 1'b1;
    pulse_vstart();
    hc_run = 1'b1;
    VC     = 9'd50;
    HC     = 9'd101;
    LPENL  = 1'b0;
    expect_hit(5);
    ticks(4);
    check("t1_lat_pre", 32'(LPSET), 32'd0);
    tick();
    check("t1_lat", 32'(LPSET), 32'd1);
    check("t1_lph", 32'(LPH), 32'd100);
    check("t1_lpv", 32'(LPV), 32'd50);
    LPENL = 1'b1;
    ticks(3);
    check("t1_hold", 32'(LPSET), 32'd1);
    pulse_lprd();
    check("t1_ack", 32'(LPSET), 32'd0);
    LPENL = 1'b0;
    ticks(10);
    check("t1_idle", 32'(LPSET), 32'd0);
    LPENL = 1'b1;
    ticks(3);

    // Glitch rejected, then a longer pulse in the same frame captures
    pulse_vstart();
    LPENL = 1'b0;
    ticks(2);
    LPENL = 1'b1;
    ticks(10);
    check("t2_glitch", 32'(LPSET), 32'd0);
    HC    = 9'd200;
    VC    = 9'd60;
    LPENL = 1'b0;
    expect_hit(5);
    ticks(6);
    LPENL = 1'b1;
    check("t2_pulse", 32'(LPSET), 32'd1);
    pulse_lprd();
    ticks(3);

    // Modular wrap of the latency correction
    pulse_vstart();
    hc_run = 1'b0;
    HC     = 9'd2;
    VC     = 9'd7;
    LPENL  = 1'b0;
    expect_hit(5);
    wait_lpset(10);
    check("t3_wrap", 32'(LPH), 32'h1FD);
    LPENL = 1'b1;
    tick();

    // Overrun while held
    HC = 9'd300;
    VC = 9'd99;
    pulse_vstart();
    check("t4_miss", 32'(LPMISS), 32'd1);
    check("t4_set", 32'(LPSET), 32'd1);
    check("t4_lph", 32'(LPH), 32'h1FD);
    check("t4_lpv", 32'(LPV), 32'd7);
    pulse_lprd();
    check("t4_ack_set", 32'(LPSET), 32'd0);
    check("t4_ack_miss", 32'(LPMISS), 32'd0);
    pulse_vstart();
    hc_run = 1'b1;
    HC     = 9'd40;
    VC     = 9'd11;
    LPENL  = 1'b0;
    expect_hit(5);
    wait_lpset(10);
    LPENL = 1'b1;
    tick();
    VSTART = 1'b1;
    LPRD   = 1'b1;
    tick();
    VSTART = 1'b0;
    LPRD   = 1'b0;
    check("t4_both_set", 32'(LPSET), 32'd0);
    check("t4_both_miss", 32'(LPMISS), 32'd0);
    LPENL = 1'b0;
    ticks(10);
    check("t4_no_arm", 32'(LPSET), 32'd0);
    LPENL = 1'b1;
    ticks(3);

    // Enable dropped mid-filter
    pulse_vstart();
    LPENL = 1'b0;
    ticks(3);
    LPEN_EN = 1'b0;
    tick();
    LPEN_EN = 1'b1;
    ticks(8);
    check("t5_en_abort", 32'(LPSET), 32'd0);
    LPENL = 1'b1;
    ticks(3);

    // Frame start in filter restarts the count, beating the completing sample
    pulse_vstart();
    HC    = 9'd120;
    VC    = 9'd22;
    LPENL = 1'b0;
    expect_hit(8);
    ticks(4);
    pulse_vstart();
    check("t5_vs_wins", 32'(LPSET), 32'd0);
    ticks(2);
    check("t5_restart_pre", 32'(LPSET), 32'd0);
    tick();
    check("t5_restart", 32'(LPSET), 32'd1);
    LPENL = 1'b1;
    pulse_lprd();
    ticks(2);

    // Async reset in filter, then pen held low with no frame start
    pulse_vstart();
    LPENL = 1'b0;
    ticks(4);
    #2;
    RESETL_0 = 1'b0;
    #1;
    check_zero("t6_rst_filter");
    @(posedge CLK);
    #1;
    RESETL_0 = 1'b1;
    ticks(12);
    check("t6_no_arm", 32'(LPSET), 32'd0);
    LPENL = 1'b1;
    ticks(3);

    // Async reset while held with an overrun flagged
    pulse_vstart();
    HC    = 9'd80;
    VC    = 9'd33;
    LPENL = 1'b0;
    expect_hit(5);
    wait_lpset(10);
    LPENL = 1'b1;
    pulse_vstart();
    check("t6_miss", 32'(LPMISS), 32'd1);
    #2;
    RESETL_0 = 1'b0;
    #1;
    check_zero("t6_rst_held");
    @(posedge CLK);
    #1;
    RESETL_0 = 1'b1;
    ticks(3);

    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
